kmc_intr_ack: RTL

//   Bus-side interrupt acknowledge controller: the responder for device interrupt requesters.
//   - Collects level IRQs from NDEV devices and presents a combined request to the CPU.
//   - On a CPU vector request, selects one device, drives its IACK for the vector cycle and captures its vector.
//   - Keeps IACK low after the vector cycle until the device drops its IRQ, so one interrupt is never taken twice.
//

---
 rtl/kmc_intr_ack.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/kmc_intr_ack.sv
// kmc_intr_ack -- bus-side interrupt acknowledge controller.
//
// Collects level IRQs from NDEV devices and presents their OR to the CPU as
// cpu_irq. On a CPU vector request it picks one requesting device, drives
// that device's IACK for VHOLD cycles, and then captures the device's vector.
// After the vector cycle, IACK stays low until the device drops its IRQ.
// This stops one interrupt from being taken twice. If the device never
// releases, a timeout ends the wait.
//
// Optional feature macro: KMC_INTR_ROUNDROBIN_EN
//   defined     -> rotating priority; the search starts after the last
//                  acknowledged device.
//   not defined -> fixed priority; the lowest device index wins.
//
// Reset (rst_n low) and bus init (intr_init high) are both synchronous and
// have the same effect.

module kmc_intr_ack #(
  parameter int NDEV  = 4,
  parameter int VECW  = 9,
  parameter int VHOLD = 3,
  parameter int TMO   = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     intr_init,
  input  logic [NDEV-1:0]          dev_irq,
  input  logic [NDEV*VECW-1:0]     dev_vect,
  output logic [NDEV-1:0]          dev_iack,
  output logic                     cpu_irq,
  input  logic                     cpu_req,
  output logic                     cpu_ack,
  output logic                     cpu_err,
  output logic [VECW-1:0]          cpu_vect,
  output logic [$clog2(NDEV)-1:0]  cpu_dev
);

  localparam int SELW = $clog2(NDEV);
  localparam int CW   = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_VECT    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  // Reset and bus init are treated as one synchronous clear.
  logic sync_clr;
  assign sync_clr = !rst_n || intr_init;

  state_t            state_q, state_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [NDEV-1:0]   iack_d;
  logic              ack_d;
  logic              err_d;
  logic [VECW-1:0]   vect_d;
  logic [SELW-1:0]   dev_d;

  logic [SELW-1:0]   pick;
  logic              any_irq;

  assign any_irq = |dev_irq;

`ifdef KMC_INTR_ROUNDROBIN_EN
  // Pointer to the last acknowledged device. It resets to NDEV-1, so the
  // first search starts at device 0.
  logic [SELW-1:0]   last_q, last_d;
  int                rr_start;
  int                rr_dist;
  int                rr_best;

  // Rotating priority: pick the requester nearest to last_q+1, going upward
  // through the device indices and wrapping at NDEV.
  always_comb begin
    pick     = '0;
    rr_start = int'(last_q) + 1;
    if (rr_start >= NDEV) rr_start = 0;
    rr_best  = NDEV;
    rr_dist  = 0;
    for (int i = 0; i < NDEV; i++) begin
      rr_dist = (i >= rr_start) ? (i - rr_start) : (i + NDEV - rr_start);
      if (dev_irq[i] && (rr_dist < rr_best)) begin
        rr_best = rr_dist;
        pick    = SELW'(i);
      end
    end
  end

  // Move the rotation pointer only when a vector is actually captured.
  always_ff @(posedge clk) begin
    if (sync_clr) last_q <= SELW'(NDEV - 1);
    else          last_q <= last_d;
  end

  assign last_d = ack_d ? sel_q : last_q;
`else
  // Fixed priority: lowest index wins. The loop runs downward so the lowest
  // requesting index is written last.
  always_comb begin
    pick = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (dev_irq[i]) pick = SELW'(i);
    end
  end
`endif

  // Next-state and next-output logic for the acknowledge sequence.
  // NOTE: every signal written here gets a default first. A path that leaves
  // a signal unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    iack_d  = dev_iack;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    vect_d  = cpu_vect;
    dev_d   = cpu_dev;

    unique case (state_q)
      S_IDLE: begin
        iack_d = '0;
        if (cpu_req) begin
          if (any_irq) begin
            sel_d        = pick;
            iack_d[pick] = 1'b1;
            cnt_d        = '0;
            state_d      = S_VECT;
          end else begin
            // Nobody is requesting, so report the empty request.
            err_d = 1'b1;
          end
        end
      end

      S_VECT: begin
        cnt_d = cnt_q + 1'b1;
        if (!dev_irq[sel_q]) begin
          // Passive release: the device withdrew before its vector was taken.
          iack_d  = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CW'(VHOLD - 1)) begin
          vect_d  = dev_vect[sel_q*VECW +: VECW];
          dev_d   = sel_q;
          ack_d   = 1'b1;
          iack_d  = '0;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end
      end

      S_RELEASE: begin
        // IACK stays low. Only the served device's IRQ matters here.
        iack_d = '0;
        cnt_d  = cnt_q + 1'b1;
        if (!dev_irq[sel_q]) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CW'(TMO - 1)) begin
          // TMO cycles have passed in RELEASE without a release.
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        iack_d  = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register for the FSM, its selected device and its cycle counter.
  // NOTE: sequential state uses non-blocking assignments. All registers then
  // update together at the edge, whatever order the processes run in.
  always_ff @(posedge clk) begin
    if (sync_clr) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Registered outputs to the devices and the CPU.
  always_ff @(posedge clk) begin
    if (sync_clr) begin
      dev_iack <= '0;
      cpu_ack  <= 1'b0;
      cpu_err  <= 1'b0;
      cpu_vect <= '0;
      cpu_dev  <= '0;
    end else begin
      dev_iack <= iack_d;
      cpu_ack  <= ack_d;
      cpu_err  <= err_d;
      cpu_vect <= vect_d;
      cpu_dev  <= dev_d;
    end
  end

  // Combined interrupt request to the CPU, registered.
  always_ff @(posedge clk) begin
    if (sync_clr) cpu_irq <= 1'b0;
    else          cpu_irq <= any_irq;
  end

  // Protocol invariants on the registered outputs.
  a_ack_err_excl : assert property (@(posedge clk) !(cpu_ack && cpu_err));
  a_iack_onehot0 : assert property (@(posedge clk) $onehot0(dev_iack));

endmodule
